serial_bus_responder: RTL
=========================

SERIAL_BUS_RESPONDER -- requirements
Module: serial_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: decode base address.
REQ-002 Parameter ADDR_MASK, default 32'hFFFF_0000: a frame hits when (addr & ADDR_MASK) == BASE_ADDR.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  frame start strobe, high in the cycle carrying address byte 0.
REQ-006 addr_in  input  8  serial address byte lane; in the rw cycle bit 0 = write flag.
REQ-007 wdata_in  input  8  serial write-data byte lane.
REQ-008 rdata_out  output  8  serial read-data byte lane.
REQ-009 rdata_oe  output  1  high while rdata_out carries valid read data.
REQ-010 busy  output  1  high from frame acceptance until frame end or memory handshake completion, whichever is later.
REQ-011 mem_req, mem_we  output  1 each  backend request and write qualifier.
REQ-012 mem_addr, mem_wdata  output  32 each  backend address and write data.
REQ-013 mem_ready  input  1  backend completion; mem_rdata  input  32  read data, valid when mem_ready is high.
REQ-014 late  output  1  sticky flag: a read response missed its deadline.
REQ-015 err_count  output  8  late-response counter (see Configuration).

Function
REQ-016 Frame timing: start sampled high in IDLE in cycle T; T..T+3 carry address and write-data bytes 0..3, LSB byte first; T+4 carries the rw cycle; T+5 is turnaround; T+6..T+9 form the read-data window.
REQ-017 FSM states: IDLE, ADDR (byte index 0..3), RW, TURN, RDATA (byte index 0..3), WAIT_MEM; from IDLE, start moves to ADDR.
REQ-018 Transitions: ADDR index 3 -> RW -> TURN -> RDATA; RDATA index 3 -> IDLE, or WAIT_MEM if the handshake is still open; WAIT_MEM -> IDLE on mem_ready.
REQ-019 start is ignored in every state except IDLE; a second start mid-frame has no effect.
REQ-020 Decode is evaluated at the end of T+4; a miss issues no mem_req, keeps rdata_oe low, and still runs the frame to completion.
REQ-021 On a hit, mem_req rises in T+5 with mem_addr, mem_wdata, and mem_we (= rw flag) stable, and holds until the cycle in which mem_ready is sampled high, inclusive.
REQ-022 Read deadline: mem_ready may be combinational in T+5; if it is sampled high in T+5, mem_rdata is registered and driven MSB byte first in T+6..T+9 with rdata_oe high.
REQ-023 Read miss: if mem_ready is not high in T+5, rdata_out is 0x00 and rdata_oe stays high in T+6..T+9, late is set, and mem_req stays high until mem_ready.
REQ-024 Writes: rdata_oe never rises and there is no deadline; mem_req holds until mem_ready, possibly into WAIT_MEM.
REQ-025 rdata_out is 0x00 whenever rdata_oe is low.
REQ-026 busy is low only in IDLE.
REQ-027 late clears only on reset.

Reset
REQ-028 rst high at a clock edge forces IDLE; all outputs are 0, including mem_addr, mem_wdata, late and err_count.
REQ-029 Reset mid-frame or during an open handshake abandons it; mem_req is low in the next cycle with no completion required.

Configuration
REQ-030 Macro SBR_ERRCOUNT_EN defined: err_count increments on each late read and saturates at 8'hFF.
REQ-031 Macro SBR_ERRCOUNT_EN undefined: err_count is tied to 0 and no counter flops exist.

Structure
REQ-032 Package sbr_pkg holds the FSM state enum, phase-length constants (ADDR_BYTES=4, DATA_BYTES=4), and the rw bit position.
REQ-033 One sub-module, sbr_byte_shift, provides a 4x8 shift register with byte-load and parallel-load modes; it is instantiated for address capture, write-data capture, and read-data output.

Verification
REQ-034 Read hit: frame addr 0x0000_1234, rw bit 0, mem_ready high in T+5 with mem_rdata 0xDEADBEEF -> mem_addr 0x0000_1234, mem_we 0, rdata_out DE,AD,BE,EF in T+6..T+9, late 0.
REQ-035 Write: addr 0x0000_0010, wdata 0xCAFEF00D, rw bit 1, mem_ready in T+7 -> mem_req high T+5..T+7, mem_wdata 0xCAFEF00D, rdata_oe never high, busy low from T+10.
REQ-036 Decode miss: addr 0x0001_0000 -> mem_req never rises, rdata_oe 0, busy drops after T+9.
REQ-037 Late read: mem_ready first high in T+11 -> rdata_out 00 with rdata_oe high in T+6..T+9, late=1, err_count=1 (macro on) or 0 (macro off), busy low from T+12.
REQ-038 start pulses at T+2 and T+7 during a read frame -> both ignored, single mem_req; start in the first IDLE cycle is accepted.
REQ-039 rst in T+6 of a read -> next cycle all outputs 0, state IDLE, a new frame accepted normally.

Source files
------------

// File: rtl/sbr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbr_pkg : shared types and frame constants for serial_bus_responder  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sbr_pkg;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;
  localparam int RW_BIT     = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_RW       = 3'd2,
    ST_TURN     = 3'd3,
    ST_RDATA    = 3'd4,
    ST_WAIT_MEM = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sbr_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbr_if : serial frame lanes and memory backend handshake             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sbr_if;

  logic        start;
  logic [7:0]  addr_in;
  logic [7:0]  wdata_in;
  logic [7:0]  rdata_out;
  logic        rdata_oe;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        late;
  logic [7:0]  err_count;

  modport slave (
    input  start, addr_in, wdata_in, mem_ready, mem_rdata,
    output rdata_out, rdata_oe, busy, mem_req, mem_we, mem_addr, mem_wdata,
           late, err_count
  );

  modport master (
    output start, addr_in, wdata_in, mem_ready, mem_rdata,
    input  rdata_out, rdata_oe, busy, mem_req, mem_we, mem_addr, mem_wdata,
           late, err_count
  );

endinterface
`default_nettype wire

// File: rtl/sbr_byte_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbr_byte_shift : 4x8 shift register, byte-in (LSB first) or parallel |
// | load, with MSB-first byte shift-out. Revision: 1.0                   |
// +----------------------------------------------------------------------+
module sbr_byte_shift
  import sbr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    par_en,
  input  logic [DATA_BYTES*8-1:0] par_in,
  input  logic                    byte_en,
  input  logic [7:0]              byte_in,
  input  logic                    shift_en,
  output logic [DATA_BYTES*8-1:0] word
);

  localparam int c_w = DATA_BYTES * 8;

  logic [c_w-1:0] r_word;

  // New bytes enter at the top so the first byte ends up in the low lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (par_en) begin
      r_word <= par_in;
    end else if (byte_en) begin
      r_word <= {byte_in, r_word[c_w-1:8]};
    end else if (shift_en) begin
      r_word <= {r_word[c_w-9:0], 8'h00};
    end
  end

  assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/serial_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_bus_responder : byte-serial frame slave bridging to a memory  |
// | backend. Optional macro SBR_ERRCOUNT_EN enables err_count. Rev 1.0   |
// +----------------------------------------------------------------------+
module serial_bus_responder
  import sbr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000
) (
  input  logic clk,
  input  logic rst,
  sbr_if.slave bus
);

  localparam logic [1:0] c_last_addr = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] c_last_data = 2'(DATA_BYTES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic        r_hit;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_late;
  logic [31:0] w_addr_word;
  logic [31:0] w_wdata_word;
  logic [31:0] w_rd_word;
  logic [23:0] w_rd_unused;
  logic        w_capture;
  logic        w_hit;
  logic        w_oe;
  logic        w_late_evt;
  logic        w_rd_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_IDLE: begin
        // Byte 0 rides with start, so ADDR begins at index 1.
        if (bus.start) begin
          w_state_nxt = ST_ADDR;
          w_idx_nxt   = 2'd1;
        end
      end
      ST_ADDR: begin
        if (r_idx == c_last_addr) begin
          w_state_nxt = ST_RW;
          w_idx_nxt   = 2'd0;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end
      ST_RW:   w_state_nxt = ST_TURN;
      ST_TURN: begin
        w_state_nxt = ST_RDATA;
        w_idx_nxt   = 2'd0;
      end
      ST_RDATA: begin
        if (r_idx == c_last_data) begin
          w_idx_nxt   = 2'd0;
          w_state_nxt = (r_mem_req && !bus.mem_ready) ? ST_WAIT_MEM : ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_capture  = ((r_state == ST_IDLE) && bus.start) || (r_state == ST_ADDR);
  assign w_hit      = ((w_addr_word & ADDR_MASK) == BASE_ADDR);
  assign w_rd_ok    = r_mem_req && !r_mem_we && bus.mem_ready;
  assign w_late_evt = (r_state == ST_TURN) && r_mem_req && !r_mem_we && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_late      <= 1'b0;
    end else begin
      if (r_state == ST_RW) begin
        r_hit <= w_hit;
        if (w_hit) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= bus.addr_in[RW_BIT];
          r_mem_addr  <= w_addr_word;
          r_mem_wdata <= w_wdata_word;
        end
      end else if (r_mem_req && bus.mem_ready) begin
        r_mem_req <= 1'b0;
      end
      if (w_late_evt) r_late <= 1'b1;
    end
  end

  sbr_byte_shift u_addr_sr (
    .clk      (clk),
    .rst      (rst),
    .par_en   (1'b0),
    .par_in   (32'h0),
    .byte_en  (w_capture),
    .byte_in  (bus.addr_in),
    .shift_en (1'b0),
    .word     (w_addr_word)
  );

  sbr_byte_shift u_wdata_sr (
    .clk      (clk),
    .rst      (rst),
    .par_en   (1'b0),
    .par_in   (32'h0),
    .byte_en  (w_capture),
    .byte_in  (bus.wdata_in),
    .shift_en (1'b0),
    .word     (w_wdata_word)
  );

  // A missed deadline loads zeros so the read window drives 0x00 bytes.
  sbr_byte_shift u_rdata_sr (
    .clk      (clk),
    .rst      (rst),
    .par_en   (r_state == ST_TURN),
    .par_in   (w_rd_ok ? bus.mem_rdata : 32'h0),
    .byte_en  (1'b0),
    .byte_in  (8'h00),
    .shift_en (r_state == ST_RDATA),
    .word     (w_rd_word)
  );

  assign w_rd_unused = w_rd_word[23:0];
  assign w_oe        = (r_state == ST_RDATA) && r_hit && !r_mem_we;

`ifdef SBR_ERRCOUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'h00;
    end else if (w_late_evt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign bus.err_count = r_err_count;
`else
  assign bus.err_count = 8'h00;
`endif

  assign bus.rdata_out = w_oe ? w_rd_word[31:24] : 8'h00;
  assign bus.rdata_oe  = w_oe;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.late      = r_late;

endmodule
`default_nettype wire
